uart_rx_pkt_ctrl: RTL and testbench
===================================

# uart_rx_pkt_ctrl

Packet-framing controller above `uart_rx` on the icestick UART path. It gates `rx_enable` and consumes received bytes. It frames them as SYNC, LEN, payload, checksum, stores the payload in a local buffer, and presents each verified packet to the downstream consumer over a valid/ready handshake. Malformed or stalled packets are dropped with an error pulse.

## Interface
- `CLK_HZ`, 12000000, system clock frequency.
- `TIMEOUT_CLKS`, 12000, inter-byte timeout in clocks (1 ms).
- `MAX_LEN`, 16, maximum payload bytes; buffer depth.
- `SYNC`, 8'hA5, start-of-packet byte.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `rx_enable`  out  1  to `uart_rx`; high while accepting bytes.
- `rx_byte`  in  8  from `uart_rx`; valid while `byte_available` is high.
- `byte_available`  in  1  from `uart_rx`; level, may stay high several clocks.
- `pkt_valid`  out  1  verified packet held in buffer.
- `pkt_ready`  in  1  consumer releases the packet.
- `pkt_len`  out  5  payload length 1..MAX_LEN; valid while `pkt_valid`.
- `pkt_rd_addr`  in  4  buffer read index.
- `pkt_rd_data`  out  8  buffer byte at `pkt_rd_addr` (registered, 1-clock latency).
- `err_pulse`  out  1  one-clock pulse on dropped packet.
- `err_code`  out  2  1 = bad length, 2 = checksum mismatch, 3 = timeout; held until next error.

## Operation
- Byte accept is the rising edge of `byte_available`: it is high this clock and was low the previous clock, while `rx_enable` is high. `rx_byte` is sampled on that same clock. At most one accept per edge.
- States: S_IDLE, S_LEN, S_DATA, S_CSUM, S_HOLD.
- S_IDLE: accept of `SYNC` moves to S_LEN. Any other byte is silently discarded; no error is raised.
- S_LEN: accepted byte L. If 1 <= L <= MAX_LEN, then store `pkt_len` = L, set csum = L, set idx = 0, and go to S_DATA. Otherwise raise error 1 and go to S_IDLE.
- S_DATA: each accept writes `buf[idx]` = byte, sets csum ^= byte, and increments idx. When idx reaches L, go to S_CSUM.
- S_CSUM: if the accepted byte equals csum, go to S_HOLD. Otherwise raise error 2 and go to S_IDLE.
- S_HOLD: `pkt_valid` = 1 and `rx_enable` = 0. Bytes on the line are lost by design. When `pkt_valid` and `pkt_ready` are both high, go to S_IDLE.
- Checksum: 8-bit XOR of LEN and all payload bytes. SYNC is excluded.
- Timeout: the counter clears on every accept and on every state entry. It increments in S_LEN, S_DATA and S_CSUM. When it reaches TIMEOUT_CLKS, raise error 3 and go to S_IDLE. It is held at 0 in S_IDLE and S_HOLD.
- An accept and a timeout expiry on the same clock: the accept wins and the counter clears.
- Error raise: `err_pulse` is high for exactly one clock and `err_code` updates on that clock.

## Timing
- Reset values: `rx_enable` = 0 during reset and 1 from the first clock after `rst` deasserts. `pkt_valid` = 0, `pkt_len` = 0, `pkt_rd_data` = 0, `err_pulse` = 0, `err_code` = 0. State is S_IDLE, counters are 0, and the edge-detect history is 0.
- Buffer contents are not reset. Asserting `rst` mid-packet or in S_HOLD aborts the packet with no error pulse.
- `pkt_valid` rises on the clock after the accepting edge of a correct checksum byte.
- `rx_enable` falls on that same clock.
- Release: with `pkt_ready` high at edge N, `pkt_valid` = 0 and `rx_enable` = 1 after edge N. A new SYNC is accepted from edge N+1.
- `pkt_ready` is ignored outside S_HOLD.
- `pkt_rd_data` reflects the `pkt_rd_addr` sampled at the previous edge.
- Buffer reads in S_HOLD always return the current packet. Reads outside S_HOLD return unspecified data.
- `err_pulse` asserts on the clock after the offending accept or the timeout expiry.

## Test plan
- Good packet: send A5, 03, 11, 22, 33, 03. Required: `pkt_valid` = 1, `pkt_len` = 3, reads of addr 0..2 return 11, 22, 33, `rx_enable` = 0. Then assert `pkt_ready`; required: `pkt_valid` = 0 and `rx_enable` = 1 on the next clock.
- Noise then sync: send 00, FF, A5, 01, 5A, 5B. Required: no `err_pulse`, `pkt_len` = 1, addr 0 returns 5A.
- Length errors: send A5, 00. Required: `err_pulse` with `err_code` = 1. Then send A5, 11 (17). Required: `err_code` = 1 again, and the block returns to S_IDLE both times.
- Checksum error: send A5, 02, 10, 20, 00 (expected 32). Required: `err_code` = 2, `pkt_valid` stays 0, and a following good packet is received correctly.
- Timeout: send A5, 04, AA, then idle 12000 clocks. Required: `err_code` = 3 exactly TIMEOUT_CLKS clocks after the AA accept. A byte arriving on the expiry clock instead resets the counter and no error is raised.
- Reset and stretched `byte_available`: assert `rst` in S_DATA; required: all outputs return to reset values and there is no `err_pulse`. Hold `byte_available` high for 5 clocks; required: exactly one byte is accepted.

Source files
------------

// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: frames bytes from uart_rx as SYNC, LEN, payload, checksum.
// Verified payloads are held in a local buffer for the consumer. Bad-length,
// checksum-mismatch and inter-byte-timeout packets are dropped with an error pulse.
module uart_rx_pkt_ctrl #(
  parameter int         CLK_HZ       = 12000000,
  parameter int         TIMEOUT_CLKS = CLK_HZ / 1000,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC         = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic       rx_enable,
  input  logic [7:0] rx_byte,
  input  logic       byte_available,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic [4:0] pkt_len,
  input  logic [3:0] pkt_rd_addr,
  output logic [7:0] pkt_rd_data,
  output logic       err_pulse,
  output logic [1:0] err_code
);

  localparam int               CNT_W     = $clog2(TIMEOUT_CLKS + 1);
  // The counter value seen on the clock whose increment would reach TIMEOUT_CLKS
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_HOLD
  } state_e;

  typedef enum logic [1:0] {
    E_NONE = 2'd0,
    E_LEN  = 2'd1,
    E_CSUM = 2'd2,
    E_TMO  = 2'd3
  } err_e;

  state_e           state_q, state_d;
  logic             ba_q;
  logic             rx_en_q, rx_en_d;
  logic             valid_q, valid_d;
  logic [4:0]       pkt_len_q, pkt_len_d;
  logic [4:0]       idx_q, idx_d;
  logic [4:0]       idx_inc;
  logic [7:0]       csum_q, csum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_pulse_q, err_pulse_d;
  err_e             err_code_q, err_code_d;
  logic [7:0]       pkt_rd_data_q;
  logic [7:0]       mem_q [0:MAX_LEN-1];

  logic             accept;
  logic             counting;
  logic             expire;
  logic             wr_en;

  // One accept per rising edge of byte_available, only while the line is enabled
  assign accept   = byte_available && !ba_q && rx_en_q;
  assign counting = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign expire   = counting && (cnt_q == CNT_LAST);
  assign idx_inc  = idx_q + 5'd1;

  // Next-state, framing, checksum and timeout logic
  always_comb begin
    state_d     = state_q;
    pkt_len_d   = pkt_len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    wr_en       = 1'b0;

    if (counting) cnt_d = cnt_q + CNT_W'(1);
    else          cnt_d = '0;

    case (state_q)
      S_IDLE: begin
        if (accept && (rx_byte == SYNC)) state_d = S_LEN;
      end
      S_LEN: begin
        if (accept) begin
          if ((rx_byte != 8'd0) && (rx_byte <= MAX_LEN_B)) begin
            pkt_len_d = rx_byte[4:0];
            csum_d    = rx_byte;
            idx_d     = '0;
            state_d   = S_DATA;
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = E_LEN;
            state_d     = S_IDLE;
          end
        end else if (expire) begin
          err_pulse_d = 1'b1;
          err_code_d  = E_TMO;
          state_d     = S_IDLE;
        end
      end
      S_DATA: begin
        if (accept) begin
          wr_en  = 1'b1;
          csum_d = csum_q ^ rx_byte;
          idx_d  = idx_inc;
          if (idx_inc == pkt_len_q) state_d = S_CSUM;
        end else if (expire) begin
          err_pulse_d = 1'b1;
          err_code_d  = E_TMO;
          state_d     = S_IDLE;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (rx_byte == csum_q) begin
            state_d = S_HOLD;
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = E_CSUM;
            state_d     = S_IDLE;
          end
        end else if (expire) begin
          err_pulse_d = 1'b1;
          err_code_d  = E_TMO;
          state_d     = S_IDLE;
        end
      end
      S_HOLD: begin
        if (pkt_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Any accept or state change restarts the inter-byte timer; accept beats expiry
    if (accept || (state_d != state_q)) cnt_d = '0;

    rx_en_d = (state_d != S_HOLD);
    valid_d = (state_d == S_HOLD);
  end

  // Control state, registered outputs and buffer read port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ba_q          <= 1'b0;
      rx_en_q       <= 1'b0;
      valid_q       <= 1'b0;
      pkt_len_q     <= '0;
      idx_q         <= '0;
      csum_q        <= '0;
      cnt_q         <= '0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= E_NONE;
      pkt_rd_data_q <= '0;
    end else begin
      state_q       <= state_d;
      ba_q          <= byte_available;
      rx_en_q       <= rx_en_d;
      valid_q       <= valid_d;
      pkt_len_q     <= pkt_len_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      cnt_q         <= cnt_d;
      err_pulse_q   <= err_pulse_d;
      err_code_q    <= err_code_d;
      pkt_rd_data_q <= mem_q[pkt_rd_addr];
    end
  end

  // Payload buffer; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[idx_q[3:0]] <= rx_byte;
  end

  assign rx_enable   = rx_en_q;
  assign pkt_valid   = valid_q;
  assign pkt_len     = pkt_len_q;
  assign pkt_rd_data = pkt_rd_data_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Testbench for uart_rx_pkt_ctrl: directed scenarios plus randomized packets
// checked against a byte-stream reference model.
module tb_uart_rx_pkt_ctrl;

  localparam int         T      = 12000;
  localparam int         MAXL   = 16;
  localparam logic [7:0] SYNC_B = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_enable;
  logic [7:0] rx_byte;
  logic       byte_available;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [4:0] pkt_len;
  logic [3:0] pkt_rd_addr;
  logic [7:0] pkt_rd_data;
  logic       err_pulse;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_rx_pkt_ctrl #(
    .CLK_HZ      (12000000),
    .TIMEOUT_CLKS(T),
    .MAX_LEN     (MAXL),
    .SYNC        (SYNC_B)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_enable     (rx_enable),
    .rx_byte       (rx_byte),
    .byte_available(byte_available),
    .pkt_valid     (pkt_valid),
    .pkt_ready     (pkt_ready),
    .pkt_len       (pkt_len),
    .pkt_rd_addr   (pkt_rd_addr),
    .pkt_rd_data   (pkt_rd_data),
    .err_pulse     (err_pulse),
    .err_code      (err_code)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;

  logic       pulse_seen;
  logic       valid_seen;
  logic [7:0] tx_q [$];
  int         exp_kind;   // 0 good, 1 bad length, 2 bad checksum, 3 no packet
  int         exp_len;
  logic [7:0] exp_pl [MAXL];

  // Count every error pulse cycle
  always @(posedge clk) if (err_pulse) err_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; accept happens at the next posedge
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_byte        = b;
    byte_available = 1'b1;
    @(negedge clk);
    pulse_seen = err_pulse;
    valid_seen = pkt_valid;
    repeat (hold - 1) @(negedge clk);
    byte_available = 1'b0;
    rx_byte        = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_all(input int hold_fixed);
    foreach (tx_q[i])
      send_byte(tx_q[i], (hold_fixed != 0) ? hold_fixed : int'($urandom_range(1, 3)),
                int'($urandom_range(1, 3)));
  endtask

  // Reference: scan for SYNC, then apply length / checksum rules to the stream
  task automatic model_eval();
    int i, l;
    logic [7:0] c;
    i = 0;
    while (i < tx_q.size() && tx_q[i] != SYNC_B) i++;
    if (i + 1 >= tx_q.size()) begin
      exp_kind = 3;
      return;
    end
    l = int'(tx_q[i+1]);
    if (l < 1 || l > MAXL) begin
      exp_kind = 1;
      return;
    end
    c = tx_q[i+1];
    for (int j = 0; j < l; j++) begin
      exp_pl[j] = tx_q[i+2+j];
      c = c ^ exp_pl[j];
    end
    exp_len  = l;
    exp_kind = (tx_q[i+2+l] == c) ? 0 : 2;
  endtask

  task automatic check_good_and_release(input int e0);
    check_eq("valid_rise", 32'(valid_seen), 1);
    check_eq("valid", 32'(pkt_valid), 1);
    check_eq("rx_en_hold", 32'(rx_enable), 0);
    check_eq("len", 32'(pkt_len), 32'(exp_len));
    check_eq("no_err", 32'(err_cnt - e0), 0);
    for (int j = 0; j < exp_len; j++) begin
      pkt_rd_addr = 4'(j);
      @(negedge clk);
      check_eq($sformatf("rd%0d", j), 32'(pkt_rd_data), 32'(exp_pl[j]));
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check_eq("valid_held", 32'(pkt_valid), 1);
    pkt_ready = 1'b1;
    @(negedge clk);
    pkt_ready = 1'b0;
    check_eq("released", 32'(pkt_valid), 0);
    check_eq("rx_en_back", 32'(rx_enable), 1);
  endtask

  task automatic run_packet(input int hold_fixed);
    int e0;
    model_eval();
    e0 = err_cnt;
    send_all(hold_fixed);
    @(negedge clk);
    if (exp_kind == 1 || exp_kind == 2) begin
      check_eq("err_timing", 32'(pulse_seen), 1);
      check_eq("err_count", 32'(err_cnt - e0), 1);
      check_eq("err_code", 32'(err_code), 32'(exp_kind));
      check_eq("err_no_valid", 32'(pkt_valid), 0);
      check_eq("err_rx_en", 32'(rx_enable), 1);
    end else if (exp_kind == 0) begin
      check_good_and_release(e0);
    end else begin
      check_eq("idle_no_err", 32'(err_cnt - e0), 0);
      check_eq("idle_no_valid", 32'(pkt_valid), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, k;
    logic seen;
    logic [7:0] c, b;
    int l, r;

    rst = 1'b1; byte_available = 1'b0; rx_byte = 8'h00; pkt_ready = 1'b0; pkt_rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_rx_en", 32'(rx_enable), 0);
    check_eq("rst_valid", 32'(pkt_valid), 0);
    check_eq("rst_len", 32'(pkt_len), 0);
    check_eq("rst_rd", 32'(pkt_rd_data), 0);
    check_eq("rst_pulse", 32'(err_pulse), 0);
    check_eq("rst_code", 32'(err_code), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rx_en_after_rst", 32'(rx_enable), 1);

    // Good packet
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    run_packet(1);
    // Noise then sync
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h5A, 8'h5B};
    run_packet(1);
    // Length errors
    tx_q = '{8'hA5, 8'h00};
    run_packet(1);
    tx_q = '{8'hA5, 8'h11};
    run_packet(1);
    // Checksum error, then good packet
    tx_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    run_packet(1);
    tx_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    run_packet(1);

    // Timeout: error exactly T clocks after the last accept
    send_byte(8'hA5, 1, 1);
    send_byte(8'h04, 1, 1);
    e0 = err_cnt;
    rx_byte = 8'hAA; byte_available = 1'b1;
    @(negedge clk);
    byte_available = 1'b0;
    k = 0; seen = 1'b0;
    while (k < T + 20 && !seen) begin
      @(negedge clk);
      k++;
      if (err_pulse) seen = 1'b1;
    end
    check_eq("tmo_seen", 32'(seen), 1);
    check_eq("tmo_clks", 32'(k), 32'(T));
    check_eq("tmo_code", 32'(err_code), 3);
    repeat (2) @(negedge clk);
    check_eq("tmo_count", 32'(err_cnt - e0), 1);
    check_eq("tmo_no_valid", 32'(pkt_valid), 0);

    // Byte accepted on the expiry clock beats the timeout
    send_byte(8'hA5, 1, 1);
    send_byte(8'h04, 1, 1);
    e0 = err_cnt;
    rx_byte = 8'hAA; byte_available = 1'b1;
    @(negedge clk);
    byte_available = 1'b0;
    repeat (T - 1) @(negedge clk);
    rx_byte = 8'hBB; byte_available = 1'b1;
    @(negedge clk);
    check_eq("expiry_no_pulse", 32'(err_pulse), 0);
    byte_available = 1'b0;
    @(negedge clk);
    send_byte(8'hCC, 1, 1);
    send_byte(8'hDD, 1, 1);
    send_byte(8'h04 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 1, 1);
    @(negedge clk);
    exp_len = 4;
    exp_pl[0] = 8'hAA; exp_pl[1] = 8'hBB; exp_pl[2] = 8'hCC; exp_pl[3] = 8'hDD;
    check_good_and_release(e0);

    // Reset mid-payload aborts silently
    send_byte(8'hA5, 1, 1);
    send_byte(8'h03, 1, 1);
    send_byte(8'h11, 1, 1);
    e0 = err_cnt;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_rx_en", 32'(rx_enable), 0);
    check_eq("mid_rst_valid", 32'(pkt_valid), 0);
    check_eq("mid_rst_len", 32'(pkt_len), 0);
    check_eq("mid_rst_rd", 32'(pkt_rd_data), 0);
    check_eq("mid_rst_pulse", 32'(err_pulse), 0);
    check_eq("mid_rst_code", 32'(err_code), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mid_rst_rx_en1", 32'(rx_enable), 1);
    check_eq("mid_rst_no_err", 32'(err_cnt - e0), 0);

    // Stretched byte_available: one accept per edge
    tx_q = '{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD};
    run_packet(5);

    // Randomized packets
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 3));
      tx_q.delete();
      if (r == 3) begin
        repeat ($urandom_range(1, 3)) begin
          b = 8'($urandom);
          if (b == SYNC_B) b = 8'h00;
          tx_q.push_back(b);
        end
      end
      tx_q.push_back(SYNC_B);
      if (r == 1) begin
        l = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 255));
        tx_q.push_back(8'(l));
      end else begin
        l = int'($urandom_range(1, MAXL));
        tx_q.push_back(8'(l));
        c = 8'(l);
        for (int j = 0; j < l; j++) begin
          b = 8'($urandom);
          tx_q.push_back(b);
          c = c ^ b;
        end
        if (r == 2) c = c ^ 8'($urandom_range(1, 255));
        tx_q.push_back(c);
      end
      run_packet(0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
